// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table and segment bit positions.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package seg7_pkg;

    // Bit positions of each segment within the 7-bit {g,f,e,d,c,b,a} bus
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high glyphs (1 = lit) for hex 0..F, table bit 0 = a ... bit 6 = g
    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Table rows are stored a..g LSB-first; routing through the index constants
    // keeps a board with a different pin order down to editing SEG_*.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
        logic [6:0] t;
        logic [6:0] r;
        t        = GLYPH_TBL[nib];
        r        = '0;
        r[SEG_A] = t[0];
        r[SEG_B] = t[1];
        r[SEG_C] = t[2];
        r[SEG_D] = t[3];
        r[SEG_E] = t[4];
        r[SEG_F] = t[5];
        r[SEG_G] = t[6];
        return r;
    endfunction

endpackage

// File: rtl/seg7_digit_mux.sv
// Selects the nibble and decimal point of the scanned digit and flags leading-zero blanking.
// Latency: combinational.
// Backpressure: none; pure function of the display registers and digit index.
module seg7_digit_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 2
) (
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_blank_lz,
    input  logic [IDX_W-1:0]        i_idx,
    output logic [3:0]              o_nibble,
    output logic                    o_dp,
    output logic                    o_blank
);

    logic w_run;

    // Walk from the most significant digit down; w_run stays high while every nibble so far is zero
    always_comb begin
        o_nibble = 4'h0;
        o_dp     = 1'b0;
        o_blank  = 1'b0;
        w_run    = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_run = w_run & (i_data[4*k +: 4] == 4'h0);
            if (IDX_W'(k) == i_idx) begin
                o_nibble = i_data[4*k +: 4];
                o_dp     = i_dp[k];
                // The rightmost digit always shows, so a zero value still reads "0"
                o_blank  = (k != 0) && i_blank_lz && w_run;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-seg scanner with tear-free frame-synchronous updates and PWM brightness.
// Latency: outputs registered, 1 cycle behind the internal slot/digit counters.
// Backpressure: none; iLOAD always accepted, last load before a frame boundary wins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BRIGHT_W       = 3,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic [NUM_DIGITS-1:0]   iDP,
    input  logic                    iBLANK_LZ,
    input  logic                    iLOAD,
    input  logic [BRIGHT_W-1:0]     iBRIGHT,
    output logic [6:0]              oSEG,
    output logic                    oDP,
    output logic [NUM_DIGITS-1:0]   oAN,
    output logic                    oFRAME,
    output logic                    oPEND
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMP_W = CNT_W + BRIGHT_W + 1;

    localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF    = (ACTIVE_LOW_SEG != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    // Scan counters
    logic [CNT_W-1:0]        r_slot;
    logic [IDX_W-1:0]        r_idx;
    logic [BRIGHT_W-1:0]     r_bright;

    // Pending (captured) and display (shown) copies of the inputs
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_blz;
    logic                    r_pend_flag;
    logic [4*NUM_DIGITS-1:0] r_disp_data;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_disp_blz;

    // Output registers
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame;

    logic                    w_slot_wrap;
    logic                    w_boundary;
    logic [BRIGHT_W-1:0]     w_bright;
    logic [CMP_W-1:0]        w_pwm_lhs;
    logic [CMP_W-1:0]        w_pwm_rhs;
    logic                    w_on;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic                    w_blank;
    logic [6:0]              w_seg_lit;
    logic [NUM_DIGITS-1:0]   w_an_sel;

    assign w_slot_wrap = (r_slot == SLOT_LAST);
    assign w_boundary  = w_slot_wrap && (r_idx == IDX_LAST);

    // Brightness is latched at slot start; in that first cycle the live input is the latched value
    assign w_bright  = (r_slot == '0) ? iBRIGHT : r_bright;
    assign w_pwm_lhs = CMP_W'(r_slot) << BRIGHT_W;
    assign w_pwm_rhs = (CMP_W'(w_bright) + CMP_W'(1)) * CMP_W'(SCAN_DIV);
    assign w_on      = (w_pwm_lhs < w_pwm_rhs);

    seg7_digit_mux #(
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W)
    ) u_digit_mux (
        .i_data     (r_disp_data),
        .i_dp       (r_disp_dp),
        .i_blank_lz (r_disp_blz),
        .i_idx      (r_idx),
        .o_nibble   (w_nibble),
        .o_dp       (w_dp),
        .o_blank    (w_blank)
    );

    assign w_seg_lit = w_blank ? 7'h00 : seg7_glyph(w_nibble);
    assign w_an_sel  = NUM_DIGITS'(1) << r_idx;

    // Slot counter, digit index and per-slot brightness latch
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_slot   <= '0;
            r_idx    <= '0;
            r_bright <= '0;
        end else begin
            if (r_slot == '0) begin
                r_bright <= iBRIGHT;
            end
            if (w_slot_wrap) begin
                r_slot <= '0;
                r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_slot <= r_slot + CNT_W'(1);
            end
        end
    end

    // Capture loads into pending; promote to display only at the frame boundary so a frame never mixes values
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_blz  <= 1'b0;
            r_pend_flag <= 1'b0;
            r_disp_data <= '0;
            r_disp_dp   <= '0;
            r_disp_blz  <= 1'b0;
        end else if (w_boundary) begin
            r_pend_flag <= 1'b0;
            if (iLOAD) begin
                r_disp_data <= iDATA;
                r_disp_dp   <= iDP;
                r_disp_blz  <= iBLANK_LZ;
            end else if (r_pend_flag) begin
                r_disp_data <= r_pend_data;
                r_disp_dp   <= r_pend_dp;
                r_disp_blz  <= r_pend_blz;
            end
        end else if (iLOAD) begin
            r_pend_data <= iDATA;
            r_pend_dp   <= iDP;
            r_pend_blz  <= iBLANK_LZ;
            r_pend_flag <= 1'b1;
        end
    end

    // Register pin-facing outputs with polarity applied; everything dark during the PWM off phase
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_an    <= AN_OFF;
            r_frame <= 1'b0;
        end else begin
            r_frame <= (r_slot == '0) && (r_idx == '0);
            if (w_on) begin
                r_seg <= (ACTIVE_LOW_SEG != 0) ? ~w_seg_lit : w_seg_lit;
                r_dp  <= (ACTIVE_LOW_SEG != 0) ? ~w_dp : w_dp;
                r_an  <= (ACTIVE_LOW_AN != 0) ? ~w_an_sel : w_an_sel;
            end else begin
                r_seg <= SEG_OFF;
                r_dp  <= DP_OFF;
                r_an  <= AN_OFF;
            end
        end
    end

    assign oSEG   = r_seg;
    assign oDP    = r_dp;
    assign oAN    = r_an;
    assign oFRAME = r_frame;
    assign oPEND  = r_pend_flag;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle slots, 2-bit brightness, active-low pins.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_seg7_scan_driver;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [15:0] iDATA = '0;
    logic [3:0]  iDP = '0;
    logic        iBLANK_LZ = 1'b0;
    logic        iLOAD = 1'b0;
    logic [1:0]  iBRIGHT = 2'd3;
    logic [6:0]  oSEG;
    logic        oDP;
    logic [3:0]  oAN;
    logic        oFRAME;
    logic        oPEND;

    int n_checks = 0;
    int n_fails  = 0;

    logic [3:0] cap_an  [16];
    logic [6:0] cap_seg [16];
    logic       cap_dp  [16];
    int         waited;

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .BRIGHT_W       (2),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_AN  (1)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iDATA     (iDATA),
        .iDP       (iDP),
        .iBLANK_LZ (iBLANK_LZ),
        .iLOAD     (iLOAD),
        .iBRIGHT   (iBRIGHT),
        .oSEG      (oSEG),
        .oDP       (oDP),
        .oAN       (oAN),
        .oFRAME    (oFRAME),
        .oPEND     (oPEND)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic load(input logic [15:0] data, input logic [3:0] dp, input logic blz);
        iDATA     = data;
        iDP       = dp;
        iBLANK_LZ = blz;
        iLOAD     = 1'b1;
        step();
        iLOAD     = 1'b0;
    endtask

    // Advance to the next oFRAME pulse (bounded) and record the 16 output samples of that frame
    task automatic capture_frame(output int w);
        w = 0;
        do begin
            step();
            w++;
        end while (!oFRAME && w < 40);
        chk("frame_found", 32'(oFRAME), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            cap_an[i]  = oAN;
            cap_seg[i] = oSEG;
            cap_dp[i]  = oDP;
        end
    endtask

    // Compare the first slot sample of each digit against expected segments and DP
    task automatic check_frame(input string tag, input logic [27:0] exp_seg, input logic [3:0] exp_dp);
        logic [3:0] ea;
        for (int k = 0; k < 4; k++) begin
            ea    = 4'hF;
            ea[k] = 1'b0;
            chk($sformatf("%s_d%0d_an", tag, k), 32'(cap_an[4*k]), 32'(ea));
            chk($sformatf("%s_d%0d_seg", tag, k), 32'(cap_seg[4*k]), 32'(exp_seg[7*k +: 7]));
            chk($sformatf("%s_d%0d_dp", tag, k), 32'(cap_dp[4*k]), 32'(exp_dp[k]));
        end
    endtask

    // Count active slot cycles per digit and any sample with more than one anode selected
    task automatic check_duty(input string tag, input int exp_on);
        int on_cnt;
        int multi;
        multi = 0;
        for (int k = 0; k < 4; k++) begin
            on_cnt = 0;
            for (int i = 4*k; i < 4*k + 4; i++) begin
                if (cap_an[i][k] == 1'b0) on_cnt++;
            end
            chk($sformatf("%s_d%0d_on", tag, k), 32'(on_cnt), 32'(exp_on));
        end
        for (int i = 0; i < 16; i++) begin
            if ($countones(~cap_an[i]) > 1) multi++;
        end
        chk($sformatf("%s_multi_an", tag), 32'(multi), 32'd0);
    endtask

    initial begin
        // 1. reset values, then scan starts at digit 0 with a frame pulse every 16 cycles
        iRST = 1'b1;
        repeat (3) step();
        chk("rst_an", 32'(oAN), 32'hF);
        chk("rst_seg", 32'(oSEG), 32'h7F);
        chk("rst_dp", 32'(oDP), 32'd1);
        chk("rst_frame", 32'(oFRAME), 32'd0);
        chk("rst_pend", 32'(oPEND), 32'd0);
        iRST = 1'b0;
        step();
        chk("start_an", 32'(oAN), 32'hE);
        chk("start_seg", 32'(oSEG), 32'h40);
        chk("start_frame", 32'(oFRAME), 32'd1);
        capture_frame(waited);
        chk("frame_period", 32'(waited), 32'd16);
        check_frame("zero", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

        // 2. mid-frame load is held pending until the boundary
        repeat (4) step();
        load(16'h12AF, 4'b0100, 1'b0);
        chk("pend_set", 32'(oPEND), 32'd1);
        capture_frame(waited);
        chk("pend_clr", 32'(oPEND), 32'd0);
        check_frame("12AF", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011);

        // 3. leading-zero blanking
        repeat (4) step();
        load(16'h0030, 4'b0000, 1'b1);
        capture_frame(waited);
        check_frame("lz0030", {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'hF);
        repeat (4) step();
        load(16'h0000, 4'b0000, 1'b1);
        capture_frame(waited);
        check_frame("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

        // 4. brightness duty per slot
        iBRIGHT = 2'd0;
        capture_frame(waited);
        check_duty("br0", 1);
        iBRIGHT = 2'd1;
        capture_frame(waited);
        check_duty("br1", 2);
        iBRIGHT = 2'd3;
        capture_frame(waited);
        check_duty("br3", 4);

        // 5a. load in the boundary cycle goes straight to display
        repeat (15) step();
        load(16'h5678, 4'b0000, 1'b0);
        chk("bypass_pend", 32'(oPEND), 32'd0);
        capture_frame(waited);
        chk("bypass_wait", 32'(waited), 32'd1);
        check_frame("5678", {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF);

        // 5b. two loads in one frame: last wins
        repeat (2) step();
        load(16'h1111, 4'b0000, 1'b0);
        repeat (3) step();
        load(16'h2222, 4'b0000, 1'b0);
        capture_frame(waited);
        check_frame("2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);

        // 6. reset mid-scan with an update pending
        repeat (4) step();
        load(16'h9999, 4'b1111, 1'b0);
        repeat (5) step();
        chk("pre_rst_an", 32'(oAN), 32'hB);
        chk("pre_rst_pend", 32'(oPEND), 32'd1);
        iRST = 1'b1;
        step();
        chk("mid_rst_an", 32'(oAN), 32'hF);
        chk("mid_rst_seg", 32'(oSEG), 32'h7F);
        chk("mid_rst_dp", 32'(oDP), 32'd1);
        chk("mid_rst_frame", 32'(oFRAME), 32'd0);
        chk("mid_rst_pend", 32'(oPEND), 32'd0);
        iRST = 1'b0;
        step();
        chk("restart_an", 32'(oAN), 32'hE);
        chk("restart_seg", 32'(oSEG), 32'h40);
        chk("restart_frame", 32'(oFRAME), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
